// File: rtl/tx_dup_tagger_pkg.sv
// Shared constants and types for the transmit-side duplicate tagger.
package eth_tx_pkg;

  localparam int ID_OFFSET_DEF = 34;
  localparam int MAX_LEN_DEF   = 2048;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  localparam int ADDR_W = addr_w(MAX_LEN_DEF);

  typedef enum logic [2:0] {
    S_ARM  = 3'd0,
    S_IDLE = 3'd1,
    S_FILL = 3'd2,
    S_SEND = 3'd3,
    S_GAP  = 3'd4
  } state_t;

endpackage

// File: rtl/tx_dup_tagger_if.sv
// Byte-stream bundle: frame input from the generator and tagged output to the MAC.
interface tx_dup_tagger_if;
  logic       tx_en_w;
  logic [7:0] txdata_w;
  logic [7:0] data_out;
  logic       en_out;

  modport master (output tx_en_w, output txdata_w, input data_out, input en_out);
  modport slave  (input tx_en_w, input txdata_w, output data_out, output en_out);
endinterface

// File: rtl/tx_dup_tagger_frame_buf.sv
// Simple dual-port frame store: one write port, one registered read port.
module frame_buf
  import eth_tx_pkg::*;
#(
  parameter int DEPTH = MAX_LEN_DEF,
  parameter int AW    = ADDR_W
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata_p1;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata_p1 <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata_p1;

endmodule

// File: rtl/tx_dup_tagger.sv
// Captures one frame, then replays it NCOPY times with the copy index
// written into the low nibble of the ID byte.
module tx_dup_tagger
  import eth_tx_pkg::*;
#(
  parameter int ID_OFFSET = ID_OFFSET_DEF,
  parameter int NCOPY     = 3,
  parameter int MAX_LEN   = MAX_LEN_DEF,
  parameter int IFG       = 12
) (
  input  logic            clk,
  input  logic            rst,
  tx_dup_tagger_if.slave  bus,
  output logic            busy,
  output logic            dropped,
  output logic            overflow
);

  localparam int AW = addr_w(MAX_LEN);
  localparam int GW = (IFG > 1) ? $clog2(IFG) : 1;
  typedef logic [AW:0]   cnt_t;
  typedef logic [GW-1:0] gap_t;
  localparam cnt_t       ID_ADDR   = cnt_t'(ID_OFFSET);
  localparam cnt_t       FULL      = cnt_t'(MAX_LEN);
  localparam logic [3:0] LAST_COPY = 4'(NCOPY);
  localparam gap_t       GAP_LAST  = gap_t'(IFG - 1);

  state_t        r_state, w_next;
  cnt_t          r_wr_addr, r_rd_addr, r_len;
  logic [3:0]    r_copy;
  gap_t          r_gap;
  logic          r_ovf_done, r_en_d;
  logic          r_vld_p1, r_id_p1;
  logic          r_en_out, r_dropped, r_overflow;
  logic [7:0]    r_data_out;

  logic          w_start, w_we, w_re, w_drop, w_ovf;
  logic [AW-1:0] w_waddr;
  logic [7:0]    w_rd_data;

  // A new frame is recognised only on a rising enable, so a frame that is
  // still running when the block returns to IDLE is never half-captured.
  assign w_start = bus.tx_en_w & ~r_en_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_ARM;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_ARM:  if (!bus.tx_en_w) w_next = S_IDLE;
      S_IDLE: if (w_start) w_next = S_FILL;
      S_FILL: if (!bus.tx_en_w) w_next = (r_wr_addr <= ID_ADDR) ? S_IDLE : S_SEND;
      S_SEND: if (r_rd_addr == r_len - cnt_t'(1)) w_next = S_GAP;
      S_GAP:  if (r_gap == GAP_LAST) w_next = (r_copy == LAST_COPY) ? S_IDLE : S_SEND;
      default: w_next = S_ARM;
    endcase
  end

  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_wr_addr[AW-1:0];
    w_re    = (r_state == S_SEND);
    w_drop  = 1'b0;
    w_ovf   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_we    = w_start;
        w_waddr = '0;
      end
      S_FILL: begin
        w_we   = bus.tx_en_w & (r_wr_addr < FULL);
        w_ovf  = bus.tx_en_w & (r_wr_addr == FULL) & ~r_ovf_done;
        w_drop = ~bus.tx_en_w & (r_wr_addr <= ID_ADDR);
      end
      S_SEND, S_GAP: w_drop = w_start;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_len      <= '0;
      r_copy     <= '0;
      r_gap      <= '0;
      r_ovf_done <= 1'b0;
      r_en_d     <= 1'b0;
    end else begin
      r_en_d <= bus.tx_en_w;
      case (r_state)
        S_IDLE: begin
          r_wr_addr  <= cnt_t'(1);
          r_ovf_done <= 1'b0;
        end
        S_FILL: begin
          if (bus.tx_en_w) begin
            if (r_wr_addr < FULL) r_wr_addr <= r_wr_addr + cnt_t'(1);
            if (w_ovf) r_ovf_done <= 1'b1;
          end else begin
            r_len     <= r_wr_addr;
            r_copy    <= 4'd1;
            r_rd_addr <= '0;
          end
        end
        S_SEND: begin
          r_rd_addr <= r_rd_addr + cnt_t'(1);
          r_gap     <= '0;
        end
        S_GAP: begin
          r_gap <= r_gap + gap_t'(1);
          if (r_gap == GAP_LAST) begin
            r_rd_addr <= '0;
            r_copy    <= r_copy + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (bus.txdata_w),
    .i_re    (w_re),
    .i_raddr (r_rd_addr[AW-1:0]),
    .o_rdata (w_rd_data)
  );

  // p1: buffer read data valid; valid and ID-position flag travel with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1   <= 1'b0;
      r_id_p1    <= 1'b0;
      r_dropped  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_vld_p1   <= w_re;
      r_id_p1    <= w_re & (r_rd_addr == ID_ADDR);
      r_dropped  <= w_drop;
      r_overflow <= w_ovf;
    end
  end

  // p2: output register; copy is stable here because GAP separates copies
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en_out   <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_en_out <= r_vld_p1;
      if (r_vld_p1) r_data_out <= r_id_p1 ? {w_rd_data[7:4], r_copy} : w_rd_data;
    end
  end

  assign bus.data_out = r_data_out;
  assign bus.en_out   = r_en_out;
  assign busy         = (r_state == S_FILL) || (r_state == S_SEND) || (r_state == S_GAP);
  assign dropped      = r_dropped;
  assign overflow     = r_overflow;

endmodule

// File: doc/tx_dup_tagger.md
# tx_dup_tagger

Transmit-side counterpart of the receive copy filter. Captures one Ethernet frame byte stream into a local buffer, then replays it NCOPY times back-to-back, overwriting the low nibble of the ID byte at offset ID_OFFSET with the copy index 1..NCOPY. The receive side of the link keys on that nibble. Sits between the frame generator and the MAC/PHY transmit interface, in the 125 MHz transmit clock domain.

## Interface
- ID_OFFSET, 34 (0x22): byte index of the ID byte, counted from 0 at the first enabled byte.
- NCOPY, 3: copies per frame; legal range 1..15.
- MAX_LEN, 2048: buffer depth in bytes; power of two.
- IFG, 12: idle cycles (en_out low) after each copy.

- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- tx_en_w  input  1  input frame enable; high for the contiguous frame bytes.
- txdata_w  input  8  input frame byte, valid when tx_en_w is high.
- data_out  output  8  output byte; registered.
- en_out  output  1  output enable; registered; high for the contiguous bytes of one copy.
- busy  output  1  high from frame capture start until the return to IDLE.
- dropped  output  1  one-cycle pulse when an input frame is discarded.
- overflow  output  1  one-cycle pulse when input exceeds MAX_LEN bytes.

## Operation
- States: ARM, IDLE, FILL, SEND, GAP.
- ARM (reset state): waits for tx_en_w low, then goes to IDLE. This prevents capture of a frame already in progress at reset release.
- IDLE: tx_en_w high -> FILL. Byte 0 is written at address 0.
- FILL: each enabled byte is written at wr_addr, and wr_addr increments.
  - Bytes beyond MAX_LEN are discarded.
  - overflow pulses once, on the first discarded byte.
  - Length saturates at MAX_LEN.
- End of frame is the first cycle with tx_en_w low in FILL:
  - length <= ID_OFFSET: pulse dropped, go to IDLE.
  - otherwise: latch length, set copy=1, go to SEND.
- SEND: reads addresses 0..length-1 in order.
  - Byte at ID_OFFSET goes out as {stored[7:4], copy[3:0]}.
  - All other bytes pass through unchanged.
  - After the last read, go to GAP.
- GAP: count IFG cycles.
  - copy < NCOPY: increment copy, go to SEND.
  - copy = NCOPY: go to IDLE.
- A frame starting (tx_en_w rising) in SEND or GAP is ignored entirely. dropped pulses on its first byte. No buffer writes occur.
- Counters: wr_addr and rd_addr are log2(MAX_LEN)+1 bits wide to hold length = MAX_LEN. copy is 4 bits.

## Timing
- Reset values: data_out=0, en_out=0, busy=0, dropped=0, overflow=0, state=ARM.
- busy goes high in the cycle after the first captured byte is sampled, and stays high through GAP of the last copy.
- Buffer read latency is 1 cycle; output register adds 1 more.
- First en_out of copy 1 is 2 cycles after the end-of-frame cycle (tx_en_w first sampled low).
- en_out is high for exactly length consecutive cycles per copy.
- Between copies: exactly IFG cycles of en_out low.
- The last copy's GAP completes before busy falls. Total busy-to-idle time ≈ length + NCOPY·(length+IFG) + 2.
- Overflow and end-of-frame in the same cycle: the overflow pulse still fires; the frame is sent truncated to MAX_LEN.
- Reset asserted mid-FILL or mid-SEND: outputs go to 0 immediately, the partial frame is lost, and the block restarts in ARM.
- data_out holds its last value when en_out is low; consumers ignore it.

## Structure
- Shared package eth_tx_pkg: the ID_OFFSET default (34), the state enum, and a MAX_LEN-derived address-width constant.
- One sub-module, frame_buf: simple dual-port RAM with MAX_LEN×8 storage, write port plus a 1-cycle registered read port, no reset on storage.
- Top level contains the FSM, the length/copy/IFG counters and the ID-nibble mux.

## Test plan
- 64-byte frame, byte 34 = 0xA0, NCOPY=3 -> three 64-cycle en_out bursts separated by 12 idle cycles. Byte 34 reads 0xA1, 0xA2, 0xA3; all other bytes are identical to the input. First burst starts 2 cycles after tx_en_w falls.
- 20-byte frame (≤ ID_OFFSET) -> dropped pulses once, en_out never rises, busy returns low.
- 2100-byte frame with MAX_LEN=2048 -> overflow pulses on byte 2048 only. Three 2048-byte copies are sent; the tag at byte 34 is correct.
- Second 64-byte frame started during the first copy's GAP -> dropped pulses on its first byte. Output is exactly the first frame's three copies; the buffer contents are not corrupted.
- tx_en_w high when rst deasserts, then a clean 64-byte frame -> the partial frame is ignored (no output, no dropped pulse), and the clean frame is sent normally.
- rst asserted during the 2nd copy -> en_out=0 and busy=0 at once. A following 64-byte frame is sent with tags 1, 2, 3.
